// File: rtl/nibble_serial_addsub_ctrl.sv
// -----------------------------------------------------------------------------
// nibble_serial_addsub_ctrl
//
// Purpose:
//   Computes a W = 4*NIBBLES bit add or subtract by time-sharing one 4-bit
//   adder/subtractor slice (B XOR M, carry-in M, four full_adder cells),
//   least significant nibble first. Operands are captured on a start
//   handshake. The inter-nibble carry lives in a register. A one-cycle done
//   pulse marks the point where o_s/o_c are valid.
//
// Parameters:
//   NIBBLES  operand width in nibbles (1..16), W = 4*NIBBLES
//
// Ports:
//   i_clk    clock, all state updates on the rising edge
//   i_rst    synchronous, active-high reset
//   i_start  request, accepted in IDLE or DONE (ignored while busy)
//   i_m      0 = A+B, 1 = A-B (two's complement), captured with start
//   i_a      operand A, captured with start
//   i_b      operand B, captured with start
//   o_busy   high while nibbles are being processed
//   o_done   one-cycle pulse, o_s/o_c valid from this cycle on
//   o_s      W-bit result (modulo 2^W)
//   o_c      final carry out (sub: 1 = no borrow, A >= B unsigned)
//   o_ovf    signed overflow, present only when ADDSUB_SEQ_OVF_EN is defined
//
// Configuration macro:
//   ADDSUB_SEQ_OVF_EN  adds the o_ovf port and its register
// -----------------------------------------------------------------------------

module full_adder (
    input  logic i_x,
    input  logic i_y,
    input  logic i_ci,
    output logic o_s,
    output logic o_co
);
    assign o_s  = i_x ^ i_y ^ i_ci;
    assign o_co = (i_x & i_y) | (i_ci & (i_x ^ i_y));
endmodule

module nibble_serial_addsub_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic                   i_m,
    input  logic [4*NIBBLES-1:0]   i_a,
    input  logic [4*NIBBLES-1:0]   i_b,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [4*NIBBLES-1:0]   o_s,
    output logic                   o_c
`ifdef ADDSUB_SEQ_OVF_EN
    ,
    output logic                   o_ovf
`endif
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_s;
    logic            r_m;
    logic            r_carry;
    logic            r_c;
    logic [IW-1:0]   r_idx;

    logic            w_accept;
    logic            w_last;
    logic [3:0]      w_a_nib;
    logic [3:0]      w_b_nib;
    logic [3:0]      w_sum;
    logic [4:0]      w_cy;

    // A new operation may start from IDLE or straight out of DONE (back-to-back).
    assign w_accept = i_start && (r_state != ST_RUN);
    assign w_last   = (r_idx == LAST_IDX);

    // Select the current nibble; subtraction inverts B and injects carry-in = m
    // through the carry register loaded at accept time.
    assign w_a_nib  = r_a[{r_idx, 2'b00} +: 4];
    assign w_b_nib  = r_b[{r_idx, 2'b00} +: 4] ^ {4{r_m}};
    assign w_cy[0]  = r_carry;

    for (genvar g = 0; g < 4; g++) begin : g_slice
        full_adder u_fa (
            .i_x  (w_a_nib[g]),
            .i_y  (w_b_nib[g]),
            .i_ci (w_cy[g]),
            .o_s  (w_sum[g]),
            .o_co (w_cy[g+1])
        );
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        w_next = r_state;
        o_busy = 1'b0;
        o_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) w_next = ST_RUN;
            end
            ST_RUN: begin
                o_busy = 1'b1;
                if (w_last) w_next = ST_DONE;
            end
            ST_DONE: begin
                o_done = 1'b1;
                w_next = i_start ? ST_RUN : ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

`ifdef ADDSUB_SEQ_OVF_EN
    logic r_ovf;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_m     <= 1'b0;
            r_s     <= '0;
            r_c     <= 1'b0;
            r_carry <= 1'b0;
            r_idx   <= '0;
`ifdef ADDSUB_SEQ_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else if (w_accept) begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_m     <= i_m;
            r_carry <= i_m;
            r_idx   <= '0;
        end else if (r_state == ST_RUN) begin
            r_s[{r_idx, 2'b00} +: 4] <= w_sum;
            r_carry <= w_cy[4];
            r_idx   <= r_idx + IW'(1);
            if (w_last) begin
                r_c <= w_cy[4];
`ifdef ADDSUB_SEQ_OVF_EN
                // Overflow: effective operands share a sign, result sign differs.
                r_ovf <= (r_a[W-1] == (r_b[W-1] ^ r_m)) && (w_sum[3] != r_a[W-1]);
`endif
            end
        end
    end

    assign o_s = r_s;
    assign o_c = r_c;
`ifdef ADDSUB_SEQ_OVF_EN
    assign o_ovf = r_ovf;
`endif

endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
// -----------------------------------------------------------------------------
// tb_nibble_serial_addsub_ctrl
//
// Directed bench for nibble_serial_addsub_ctrl with NIBBLES=4 (W=16). Expected
// values are hand-computed constants. Inputs change 1 time unit after the
// rising edge; outputs are sampled at the same point.
// -----------------------------------------------------------------------------

module tb_nibble_serial_addsub_ctrl;
    localparam int NIBBLES = 4;
    localparam int W = 4 * NIBBLES;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         m;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         c;
`ifdef ADDSUB_SEQ_OVF_EN
    logic         ovf;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    nibble_serial_addsub_ctrl #(.NIBBLES(NIBBLES)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (start),
        .i_m     (m),
        .i_a     (a),
        .i_b     (b),
        .o_busy  (busy),
        .o_done  (done),
        .o_s     (s),
        .o_c     (c)
`ifdef ADDSUB_SEQ_OVF_EN
        ,
        .o_ovf   (ovf)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a start for exactly one edge, then release it.
    task automatic issue(input logic op_m, input logic [W-1:0] op_a, input logic [W-1:0] op_b);
        start = 1'b1;
        m     = op_m;
        a     = op_a;
        b     = op_b;
        tick();
        start = 1'b0;
    endtask

    // Full operation from an idle DUT: busy for NIBBLES cycles, then done.
    task automatic run_op(input string tag, input logic op_m, input logic [W-1:0] op_a,
                          input logic [W-1:0] op_b, input logic [W-1:0] exp_s, input logic exp_c);
        issue(op_m, op_a, op_b);
        for (int i = 0; i < NIBBLES; i++) begin
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_nodone"}, 32'(done), 32'd0);
            tick();
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy_lo"}, 32'(busy), 32'd0);
        check({tag, "_s"}, 32'(s), 32'(exp_s));
        check({tag, "_c"}, 32'(c), 32'(exp_c));
        tick();
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_s_hold"}, 32'(s), 32'(exp_s));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        m     = 1'b0;
        a     = '0;
        b     = '0;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_s", 32'(s), 32'd0);
        check("rst_c", 32'(c), 32'd0);

        // Reset wins over a simultaneous start.
        start = 1'b1;
        a     = 16'h1111;
        b     = 16'h2222;
        tick();
        check("rst_vs_start_busy", 32'(busy), 32'd0);
        start = 1'b0;
        rst   = 1'b0;
        tick();

        // Basic add and full carry ripple.
        run_op("add1", 1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0);
        run_op("add_ripple", 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1);

        // Subtract, with and without borrow.
        run_op("sub_nb", 1'b1, 16'h0007, 16'h0005, 16'h0002, 1'b1);
        run_op("sub_b", 1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0);

        // Start during RUN is ignored; start in DONE is accepted back-to-back.
        issue(1'b0, 16'h1234, 16'h4321);
        check("ign_busy0", 32'(busy), 32'd1);
        start = 1'b1;
        a     = 16'hAAAA;
        b     = 16'h1111;
        m     = 1'b1;
        tick();
        start = 1'b0;
        check("ign_busy1", 32'(busy), 32'd1);
        tick();
        tick();
        check("ign_busy3", 32'(busy), 32'd1);
        tick();
        check("ign_done", 32'(done), 32'd1);
        check("ign_s", 32'(s), 32'h5555);
        check("ign_c", 32'(c), 32'd0);
        issue(1'b0, 16'h0100, 16'h0200);
        check("b2b_busy", 32'(busy), 32'd1);
        check("b2b_nodone", 32'(done), 32'd0);
        tick();
        tick();
        tick();
        check("b2b_busy3", 32'(busy), 32'd1);
        tick();
        check("b2b_done", 32'(done), 32'd1);
        check("b2b_s", 32'(s), 32'h0300);
        check("b2b_c", 32'(c), 32'd0);
        tick();
        check("b2b_idle", 32'(done), 32'd0);

        // Leave c=1 from a completed operation, then abort one mid-RUN.
        run_op("sub_c1", 1'b1, 16'h0007, 16'h0005, 16'h0002, 1'b1);
        issue(1'b0, 16'h1234, 16'h4321);
        tick();
        tick();
        check("abort_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_s", 32'(s), 32'd0);
        check("abort_c", 32'(c), 32'd0);
        for (int i = 0; i < NIBBLES + 2; i++) begin
            tick();
            check("abort_no_done", 32'(done), 32'd0);
        end

        // Recovery after abort.
        run_op("recover", 1'b0, 16'h00F0, 16'h0010, 16'h0100, 1'b0);

`ifdef ADDSUB_SEQ_OVF_EN
        run_op("ovf_add", 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0);
        check("ovf_add_flag", 32'(ovf), 32'd1);
        run_op("ovf_sub", 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1);
        check("ovf_sub_flag", 32'(ovf), 32'd1);
        run_op("ovf_none", 1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0);
        check("ovf_none_flag", 32'(ovf), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
